spr_file: RTL and testbench
===========================

Name: spr_file

Overview:
- Responder end of the special-purpose-register move path.
- Holds the architected SPRs that the SPR execution unit targets with mtspr (GPR to SPR) and mfspr (SPR to GPR).
- Serves read and write requests from the pipeline over a valid/ready request channel and a registered response channel.
- Contains SPRG scratch registers, a 64-bit timebase and a decrementer that raises a level interrupt to the exception logic.

Parameters:
- TB_DIV, 1: timebase/decrementer tick period in clk cycles (≥1).
- NUM_SPRG, 4: number of SPRG registers (1..4), mapped at SPR 272+i.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid & req_ready
- req_write  in  1  1 = mtspr, 0 = mfspr
- req_sel  in  10  SPR number, already un-swizzled
- req_data  in  32  write data (Pu_types::Word)
- resp_valid  out  1  response present
- resp_ready  in  1  consumer takes response
- resp_data  out  32  read data; 0 for writes
- resp_err  out  1  unmapped SPR, or write to a read-only number
- tb_enable  in  1  timebase/decrementer run enable
- dec_irq  out  1  decrementer interrupt pending, level
- dec_ack  in  1  clears dec_irq

Behaviour:
- Reset: all SPRGs, TB, DEC, prescaler = 0; resp_valid = 0, resp_data = 0, resp_err = 0, dec_irq = 0. Reset mid-transaction discards the pending response.
- Handshake: req_ready = !resp_valid | resp_ready (combinational).
  - An accepted request produces resp_valid on the next edge; latency 1.
  - Back-to-back accepts are allowed when resp_ready = 1.
  - resp_valid, resp_data and resp_err hold stable until resp_valid & resp_ready.
- Map:
  - DEC = 22 (rw).
  - TBL read = 268, TBU read = 269 (ro).
  - TBL write = 284, TBU write = 285 (wo).
  - SPRG i = 272+i (rw, i < NUM_SPRG).
- Errors:
  - Write to 268/269 returns err.
  - Read of 284/285 returns err with data 0.
  - Any other number returns err; writes to it are ignored.
- Read data is the register value before any same-cycle tick, i.e. the value at the accepting edge.
- Tick: a prescaler counts 0..TB_DIV-1 while tb_enable = 1. A tick fires on wrap; the prescaler holds when tb_enable = 0.
- On tick:
  - TB += 1 with full 64-bit carry; 0xFFFFFFFF_FFFFFFFF wraps to 0.
  - DEC -= 1, 0 wraps to 0xFFFFFFFF.
- Interrupt: dec_irq sets when a tick moves DEC bit 0 from 0 to 1 (the 0x00000000 -> 0xFFFFFFFF transition).
  - dec_irq clears on dec_ack, or on a DEC write with data bit 0 = 0.
  - If set and clear coincide, set wins.
  - Bit numbering is big-endian, as in Pu_types: bit 0 is the MSB.
- Write vs tick in the same cycle: the write wins.
  - TBL write replaces the low word and suppresses the increment; the upper word is untouched and gets no carry.
  - TBU write likewise for the high word.
  - A DEC write suppresses the decrement and cannot itself set dec_irq.

Decomposition:
- Pu_types gets:
  - Spr_num (10-bit) typedef.
  - Constants SPR_DEC, SPR_TBL_R, SPR_TBU_R, SPR_TBL_W, SPR_TBU_W, SPR_SPRG0.
  - A Spr_req struct {write, sel, data}.
- One sub-module, spr_timebase: prescaler, 64-bit TB, DEC and dec_irq logic. It has write-strobe inputs and a tick output.
- Decode and the response register stay in spr_file.

Test Plan:
- SPRG round-trip: write SPR 273 = 0xDEADBEEF, then read 273 → resp_data 0xDEADBEEF, err 0. Reading 272 → 0.
- Backpressure: hold resp_ready = 0 after a read of 272.
  - req_ready must drop.
  - A second req_valid must not be accepted.
  - Response stable for 5 cycles.
  - Release → both requests complete in order.
- TB carry: write TBL 0xFFFFFFFE, TBU 0x00000001, tb_enable = 1, TB_DIV = 1. Two ticks later read 269 → 0x00000002 and 268 → 0x00000000 (+ elapsed ticks).
- DEC underflow: write DEC = 2, enable.
  - dec_irq rises exactly on the third tick (DEC = 0xFFFFFFFF).
  - dec_ack clears it.
  - Writing DEC = 0x80000000 does not clear it; writing 0x00000005 does.
- Unmapped access: write to SPR 1000 → resp_err = 1, no state change. Read 284 → err 1, data 0.
- Reset during a pending response: assert reset with resp_valid = 1 → resp_valid = 0 asynchronously, TB = DEC = 0, dec_irq = 0.

Source files
------------

// File: rtl/spr_file_pkg.sv
// Shared types and SPR numbers for the special-purpose-register move path.
// Bit numbering follows the big-endian convention: bit 0 is the MSB of a word.
package spr_file_pkg;

    typedef logic [9:0]  spr_num_t;
    typedef logic [31:0] word_t;

    localparam spr_num_t SPR_DEC   = 10'd22;
    localparam spr_num_t SPR_TBL_R = 10'd268;
    localparam spr_num_t SPR_TBU_R = 10'd269;
    localparam spr_num_t SPR_SPRG0 = 10'd272;
    localparam spr_num_t SPR_TBL_W = 10'd284;
    localparam spr_num_t SPR_TBU_W = 10'd285;

    typedef struct packed {
        logic     write;
        spr_num_t sel;
        word_t    data;
    } spr_req_t;

    // Big-endian bit select: n = 0 addresses the most significant bit.
    function automatic logic be_bit(input word_t w, input int n);
        return w[31-n];
    endfunction

endpackage

// File: rtl/spr_timebase.sv
// Prescaler, 64-bit timebase and decrementer with its level interrupt.
// Register writes take priority over a same-cycle tick.
module spr_timebase
    import spr_file_pkg::*;
#(
    parameter int TB_DIV = 1
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        tb_enable_i,
    input  logic        tbl_we_i,
    input  logic        tbu_we_i,
    input  logic        dec_we_i,
    input  word_t       wdata_i,
    input  logic        dec_ack_i,
    output logic [63:0] tb_o,
    output word_t       dec_o,
    output logic        dec_irq_o,
    output logic        tick_o
);

    localparam int PW = (TB_DIV > 1) ? $clog2(TB_DIV) : 1;

    logic [PW-1:0] presc_q, presc_d;
    logic [63:0]   tb_q, tb_d;
    word_t         dec_q, dec_d;
    logic          irq_q, irq_d;
    logic          tick;
    logic          irq_set, irq_clr;

    always_comb begin
        tick    = tb_enable_i && (presc_q == PW'(TB_DIV - 1));
        presc_d = presc_q;
        if (tb_enable_i) begin
            presc_d = tick ? '0 : presc_q + PW'(1);
        end

        // Any TB write suppresses the whole increment, so no carry crosses words.
        tb_d = tb_q;
        if (tbl_we_i) begin
            tb_d[31:0] = wdata_i;
        end else if (tbu_we_i) begin
            tb_d[63:32] = wdata_i;
        end else if (tick) begin
            tb_d = tb_q + 64'd1;
        end

        dec_d = dec_q;
        if (dec_we_i) begin
            dec_d = wdata_i;
        end else if (tick) begin
            dec_d = dec_q - 32'd1;
        end

        irq_set = tick && !dec_we_i && !be_bit(dec_q, 0) && be_bit(dec_d, 0);
        irq_clr = dec_ack_i || (dec_we_i && !be_bit(wdata_i, 0));
        irq_d   = irq_set ? 1'b1 : (irq_clr ? 1'b0 : irq_q);
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            presc_q <= '0;
            tb_q    <= '0;
            dec_q   <= '0;
            irq_q   <= 1'b0;
        end else begin
            presc_q <= presc_d;
            tb_q    <= tb_d;
            dec_q   <= dec_d;
            irq_q   <= irq_d;
        end
    end

    assign tb_o      = tb_q;
    assign dec_o     = dec_q;
    assign dec_irq_o = irq_q;
    assign tick_o    = tick;

endmodule

// File: rtl/spr_file.sv
// SPR responder: decodes mtspr/mfspr requests, holds the SPRGs and returns a
// registered response one cycle after acceptance.
module spr_file
    import spr_file_pkg::*;
#(
    parameter int TB_DIV   = 1,
    parameter int NUM_SPRG = 4
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_write_i,
    input  logic [9:0]  req_sel_i,
    input  logic [31:0] req_data_i,
    output logic        resp_valid_o,
    input  logic        resp_ready_i,
    output logic [31:0] resp_data_o,
    output logic        resp_err_o,
    input  logic        tb_enable_i,
    output logic        dec_irq_o,
    input  logic        dec_ack_i
);

    // Handshake: a request transfers on req_valid & req_ready; a response
    // transfers on resp_valid & resp_ready and is held stable until then.
    spr_req_t      req;
    logic          accept;
    logic          resp_valid_q;
    word_t         resp_data_q, resp_data_d;
    logic          resp_err_q, resp_err_d;
    word_t         sprg_q [NUM_SPRG];
    logic [NUM_SPRG-1:0] sprg_we;
    logic          dec_we, tbl_we, tbu_we;
    logic [63:0]   tb;
    word_t         dec;
    logic          tick_unused;

    assign req         = '{write: req_write_i, sel: req_sel_i, data: req_data_i};
    assign req_ready_o = !resp_valid_q || resp_ready_i;
    assign accept      = req_valid_i && req_ready_o;

    always_comb begin
        resp_data_d = '0;
        resp_err_d  = 1'b0;
        dec_we      = 1'b0;
        tbl_we      = 1'b0;
        tbu_we      = 1'b0;
        sprg_we     = '0;
        case (req.sel)
            SPR_DEC: begin
                if (req.write) dec_we = accept;
                else           resp_data_d = dec;
            end
            SPR_TBL_R: begin
                if (req.write) resp_err_d = 1'b1;
                else           resp_data_d = tb[31:0];
            end
            SPR_TBU_R: begin
                if (req.write) resp_err_d = 1'b1;
                else           resp_data_d = tb[63:32];
            end
            SPR_TBL_W: begin
                if (req.write) tbl_we = accept;
                else           resp_err_d = 1'b1;
            end
            SPR_TBU_W: begin
                if (req.write) tbu_we = accept;
                else           resp_err_d = 1'b1;
            end
            default: begin
                resp_err_d = 1'b1;
                for (int i = 0; i < NUM_SPRG; i++) begin
                    if (req.sel == SPR_SPRG0 + spr_num_t'(i)) begin
                        resp_err_d = 1'b0;
                        if (req.write) sprg_we[i] = accept;
                        else           resp_data_d = sprg_q[i];
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            resp_err_q   <= 1'b0;
        end else if (accept) begin
            resp_valid_q <= 1'b1;
            resp_data_q  <= resp_data_d;
            resp_err_q   <= resp_err_d;
        end else if (resp_ready_i) begin
            resp_valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < NUM_SPRG; i++) sprg_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_SPRG; i++) begin
                if (sprg_we[i]) sprg_q[i] <= req.data;
            end
        end
    end

    spr_timebase #(.TB_DIV(TB_DIV)) u_timebase (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .tb_enable_i (tb_enable_i),
        .tbl_we_i    (tbl_we),
        .tbu_we_i    (tbu_we),
        .dec_we_i    (dec_we),
        .wdata_i     (req.data),
        .dec_ack_i   (dec_ack_i),
        .tb_o        (tb),
        .dec_o       (dec),
        .dec_irq_o   (dec_irq_o),
        .tick_o      (tick_unused)
    );

    assign resp_valid_o = resp_valid_q;
    assign resp_data_o  = resp_data_q;
    assign resp_err_o   = resp_err_q;

endmodule

// File: tb/tb_spr_file.sv
// Directed bench for spr_file: SPRG round trip, backpressure, error map,
// timebase carry, decrementer interrupt and reset with a pending response.
module tb_spr_file;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [9:0]  req_sel;
    logic [31:0] req_data;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic        resp_err;
    logic        tb_enable;
    logic        dec_irq;
    logic        dec_ack;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    spr_file #(.TB_DIV(1), .NUM_SPRG(4)) dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_write_i  (req_write),
        .req_sel_i    (req_sel),
        .req_data_i   (req_data),
        .resp_valid_o (resp_valid),
        .resp_ready_i (resp_ready),
        .resp_data_o  (resp_data),
        .resp_err_o   (resp_err),
        .tb_enable_i  (tb_enable),
        .dec_irq_o    (dec_irq),
        .dec_ack_i    (dec_ack)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One request with resp_ready = 1; called at a point away from the clock edge.
    task automatic xact(input logic w, input logic [9:0] s, input logic [31:0] d,
                        input logic [31:0] exp_d, input logic exp_e, input string tag);
        req_write = w;
        req_sel   = s;
        req_data  = d;
        req_valid = 1'b1;
        check($sformatf("%s req_ready", tag), req_ready, 1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check($sformatf("%s resp_valid", tag), resp_valid, 1);
        check($sformatf("%s resp_data", tag), resp_data, exp_d);
        check($sformatf("%s resp_err", tag), resp_err, exp_e);
    endtask

    task automatic tick_cycles(input int n);
        tb_enable = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        tb_enable = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_sel    = '0;
        req_data   = '0;
        resp_ready = 1'b1;
        tb_enable  = 1'b0;
        dec_ack    = 1'b0;

        #2;
        check("reset resp_valid", resp_valid, 0);
        check("reset resp_data", resp_data, 0);
        check("reset resp_err", resp_err, 0);
        check("reset dec_irq", dec_irq, 0);
        check("reset req_ready", req_ready, 1);
        #10;
        reset = 1'b0;
        @(posedge clk);
        #1;

        // SPRG round trip
        xact(1, 10'd273, 32'hDEADBEEF, 32'h0, 0, "wr sprg1");
        xact(0, 10'd273, 32'h0, 32'hDEADBEEF, 0, "rd sprg1");
        xact(0, 10'd272, 32'h0, 32'h0, 0, "rd sprg0");

        // Backpressure: response held, second request waits
        resp_ready = 1'b0;
        req_write  = 1'b0;
        req_sel    = 10'd272;
        req_valid  = 1'b1;
        @(posedge clk);
        #1;
        check("bp first valid", resp_valid, 1);
        check("bp req_ready low", req_ready, 0);
        req_sel = 10'd273;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("bp hold valid %0d", k), resp_valid, 1);
            check($sformatf("bp hold data %0d", k), resp_data, 0);
            check($sformatf("bp hold err %0d", k), resp_err, 0);
            check($sformatf("bp hold ready %0d", k), req_ready, 0);
        end
        resp_ready = 1'b1;
        #1;
        check("bp release ready", req_ready, 1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("bp second valid", resp_valid, 1);
        check("bp second data", resp_data, 32'hDEADBEEF);
        check("bp second err", resp_err, 0);
        @(posedge clk);
        #1;
        check("bp drained", resp_valid, 0);

        // Error map
        xact(1, 10'd1000, 32'h12345678, 32'h0, 1, "wr unmapped");
        xact(0, 10'd1000, 32'h0, 32'h0, 1, "rd unmapped");
        xact(0, 10'd284, 32'h0, 32'h0, 1, "rd tbl_w");
        xact(0, 10'd285, 32'h0, 32'h0, 1, "rd tbu_w");
        xact(1, 10'd268, 32'h55, 32'h0, 1, "wr tbl_r");
        xact(1, 10'd276, 32'h77, 32'h0, 1, "wr sprg4");
        xact(0, 10'd273, 32'h0, 32'hDEADBEEF, 0, "sprg1 intact");
        xact(0, 10'd268, 32'h0, 32'h0, 0, "tbl intact");

        // Timebase carry across the word boundary
        xact(1, 10'd22, 32'h100, 32'h0, 0, "wr dec 100");
        xact(1, 10'd284, 32'hFFFFFFFE, 32'h0, 0, "wr tbl");
        xact(1, 10'd285, 32'h1, 32'h0, 0, "wr tbu");
        xact(0, 10'd268, 32'h0, 32'hFFFFFFFE, 0, "rd tbl pre");
        xact(0, 10'd269, 32'h0, 32'h1, 0, "rd tbu pre");
        tick_cycles(2);
        xact(0, 10'd269, 32'h0, 32'h2, 0, "rd tbu carry");
        xact(0, 10'd268, 32'h0, 32'h0, 0, "rd tbl carry");
        xact(0, 10'd22, 32'h0, 32'hFE, 0, "rd dec fe");
        check("no irq after carry", dec_irq, 0);

        // Write wins over a same-cycle tick (DEC still ticks)
        tb_enable = 1'b1;
        xact(1, 10'd284, 32'h50, 32'h0, 0, "wr tbl tick");
        tb_enable = 1'b0;
        xact(0, 10'd268, 32'h0, 32'h50, 0, "tbl no inc");
        xact(0, 10'd269, 32'h0, 32'h2, 0, "tbu untouched");
        xact(0, 10'd22, 32'h0, 32'hFD, 0, "rd dec fd");

        // Decrementer underflow raises dec_irq on the third tick
        xact(1, 10'd22, 32'h2, 32'h0, 0, "wr dec 2");
        tb_enable = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("dec tick %0d irq", k), dec_irq, (k == 3));
        end
        tb_enable = 1'b0;
        xact(0, 10'd22, 32'h0, 32'hFFFFFFFF, 0, "rd dec wrap");
        dec_ack = 1'b1;
        @(posedge clk);
        #1;
        dec_ack = 1'b0;
        check("irq ack clear", dec_irq, 0);

        xact(1, 10'd22, 32'h0, 32'h0, 0, "wr dec 0");
        check("dec write no set", dec_irq, 0);
        tick_cycles(1);
        check("irq re-set", dec_irq, 1);
        xact(1, 10'd22, 32'h80000000, 32'h0, 0, "wr dec msb");
        check("msb write keeps irq", dec_irq, 1);
        xact(1, 10'd22, 32'h5, 32'h0, 0, "wr dec 5");
        check("lsb write clears irq", dec_irq, 0);
        xact(0, 10'd22, 32'h0, 32'h5, 0, "rd dec 5");

        // Set and ack in the same cycle: set wins
        xact(1, 10'd22, 32'h0, 32'h0, 0, "wr dec 0b");
        dec_ack = 1'b1;
        tick_cycles(1);
        dec_ack = 1'b0;
        check("set beats ack", dec_irq, 1);

        // Reset while a response is pending
        resp_ready = 1'b0;
        req_write  = 1'b0;
        req_sel    = 10'd273;
        req_valid  = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("pending valid", resp_valid, 1);
        check("pending data", resp_data, 32'hDEADBEEF);
        #2;
        reset = 1'b1;
        #1;
        check("async rst valid", resp_valid, 0);
        check("async rst data", resp_data, 0);
        check("async rst irq", dec_irq, 0);
        check("async rst ready", req_ready, 1);
        #3;
        reset      = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        check("post rst valid", resp_valid, 0);
        xact(0, 10'd22, 32'h0, 32'h0, 0, "rst dec");
        xact(0, 10'd268, 32'h0, 32'h0, 0, "rst tbl");
        xact(0, 10'd269, 32'h0, 32'h0, 0, "rst tbu");
        xact(0, 10'd273, 32'h0, 32'h0, 0, "rst sprg1");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
